// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter.
// State encoding and bit-order constants used by the FSM and the shift register.
// Optional feature macro: PISO_PARITY_EN (adds the PARITY state to the word).
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam bit MSB_FIRST_ORDER = 1'b1;
    localparam bit LSB_FIRST_ORDER = 1'b0;

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable WIDTH-bit shift register with asynchronous reset.
// Load has priority over shift. next_bit is the bit that becomes the
// head of the word after the next shift, so the transmitter can register
// it straight into its serial output flop.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             next_bit
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;

    // Select the next register contents: load a new word, shift toward the head, or hold.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = din;
        end else if (shift_en) begin
            if (MSB_FIRST == LSB_FIRST_ORDER) begin
                q_next = {1'b0, q[WIDTH-1:1]};
            end else begin
                q_next = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // d_ff-style storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign next_bit = (MSB_FIRST == LSB_FIRST_ORDER) ? q[1] : q[WIDTH-2];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load handshake.
// A word is accepted on load_valid & load_ready and its first bit leaves on
// sout the following cycle, framed by frame (first bit) and done (last bit).
// A new word can be accepted on the final cycle of the current one so words
// stream back to back without gaps.
// Optional feature macro: PISO_PARITY_EN appends an even parity bit cycle.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_bit;
    logic          shift_en;
    logic          next_bit;
    logic          first_bit;
`ifdef PISO_PARITY_EN
    logic          parity_q;
`endif

    assign accept    = load_valid && load_ready;
    assign last_bit  = (cnt == LAST_IDX);
    assign shift_en  = (state == SHIFT) && !last_bit;
    assign first_bit = (MSB_FIRST == MSB_FIRST_ORDER) ? din[WIDTH-1] : din[0];

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift_en (shift_en),
        .din      (din),
        .next_bit (next_bit)
    );

    // Word sequencing FSM: handshake, bit counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            frame      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        sout       <= first_bit;
                        sout_valid <= 1'b1;
                        frame      <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
                        parity_q   <= ^din;
`endif
                    end
                end

                SHIFT: begin
                    if (!last_bit) begin
                        cnt        <= cnt + 1'b1;
                        sout       <= next_bit;
                        frame      <= 1'b0;
`ifdef PISO_PARITY_EN
                        done       <= 1'b0;
                        load_ready <= 1'b0;
`else
                        done       <= (cnt == PENULT_IDX);
                        load_ready <= (cnt == PENULT_IDX);
`endif
                    end
`ifdef PISO_PARITY_EN
                    else begin
                        state      <= PARITY;
                        sout       <= parity_q;
                        frame      <= 1'b0;
                        done       <= 1'b1;
                        load_ready <= 1'b1;
                    end
`else
                    else if (accept) begin
                        cnt        <= '0;
                        sout       <= first_bit;
                        sout_valid <= 1'b1;
                        frame      <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        load_ready <= 1'b0;
                    end else begin
                        state      <= IDLE;
                        cnt        <= '0;
                        sout_valid <= 1'b0;
                        frame      <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        load_ready <= 1'b1;
                    end
`endif
                end

`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (accept) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        sout       <= first_bit;
                        sout_valid <= 1'b1;
                        frame      <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        load_ready <= 1'b0;
                        parity_q   <= ^din;
                    end else begin
                        state      <= IDLE;
                        cnt        <= '0;
                        sout_valid <= 1'b0;
                        frame      <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end
`endif

                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    sout_valid <= 1'b0;
                    frame      <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed testbench for piso_tx (WIDTH=8), one MSB-first and one LSB-first
// instance sharing the same stimulus. Build with PISO_PARITY_EN defined to
// exercise the parity cycle.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] din;

    logic m_load_ready, m_sout, m_sout_valid, m_frame, m_busy, m_done;
    logic l_load_ready, l_sout, l_sout_valid, l_frame, l_busy, l_done;

    int checks   = 0;
    int failures = 0;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (m_load_ready),
        .din        (din),
        .sout       (m_sout),
        .sout_valid (m_sout_valid),
        .frame      (m_frame),
        .busy       (m_busy),
        .done       (m_done)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (l_load_ready),
        .din        (din),
        .sout       (l_sout),
        .sout_valid (l_sout_valid),
        .frame      (l_frame),
        .busy       (l_busy),
        .done       (l_done)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d);
        load_valid = v;
        din        = d;
    endtask

    task automatic check_output(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input bit lsb, input logic e_sout,
                               input logic e_valid, input logic e_frame, input logic e_busy,
                               input logic e_done, input logic e_ready);
        check_output({tag, " sout"},       lsb ? l_sout       : m_sout,       e_sout);
        check_output({tag, " sout_valid"}, lsb ? l_sout_valid : m_sout_valid, e_valid);
        check_output({tag, " frame"},      lsb ? l_frame      : m_frame,      e_frame);
        check_output({tag, " busy"},       lsb ? l_busy       : m_busy,       e_busy);
        check_output({tag, " done"},       lsb ? l_done       : m_done,       e_done);
        check_output({tag, " load_ready"}, lsb ? l_load_ready : m_load_ready, e_ready);
    endtask

    task automatic check_idle(input string tag, input bit lsb);
        check_output({tag, " sout_valid"}, lsb ? l_sout_valid : m_sout_valid, 1'b0);
        check_output({tag, " frame"},      lsb ? l_frame      : m_frame,      1'b0);
        check_output({tag, " busy"},       lsb ? l_busy       : m_busy,       1'b0);
        check_output({tag, " done"},       lsb ? l_done       : m_done,       1'b0);
        check_output({tag, " load_ready"}, lsb ? l_load_ready : m_load_ready, 1'b1);
    endtask

    // Called on the first bit cycle of a word; returns on its final cycle
    // (or after nbits bits when cut short). toggle wiggles load_valid/din mid-word.
    task automatic check_word(input string tag, input bit lsb, input logic [7:0] w,
                              input int nbits, input bit toggle);
        logic e;
        logic last;
        for (int i = 0; i < 8 && i < nbits; i++) begin
            e    = lsb ? w[i] : w[7-i];
            last = (i == 7) && !PAR_EN;
            check_cycle($sformatf("%s bit%0d", tag, i), lsb, e, 1'b1, (i == 0), 1'b1, last, last);
            if (i < 7 && i < nbits - 1) begin
                if (toggle) apply_stimulus((i < 6) && i[0], 8'h3C);
                else        load_valid = 1'b0;
                tick();
            end
        end
`ifdef PISO_PARITY_EN
        if (nbits > 8) begin
            load_valid = 1'b0;
            tick();
            check_cycle({tag, " parity"}, lsb, ^w, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check_cycle("reset msb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_cycle("reset lsb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        check_idle("post reset", 1'b0);

        // Single MSB-first word
        apply_stimulus(1'b1, 8'hA5);
        tick();
        check_word("a5", 1'b0, 8'hA5, 9, 1'b0);
        load_valid = 1'b0;
        tick();
        check_idle("a5 idle", 1'b0);

        // Single LSB-first word
        apply_stimulus(1'b1, 8'h01);
        tick();
        check_word("lsb01", 1'b1, 8'h01, 9, 1'b0);
        load_valid = 1'b0;
        tick();
        check_idle("lsb01 idle", 1'b1);

        // Back-to-back streaming
        apply_stimulus(1'b1, 8'hFF);
        tick();
        check_word("b2b ff", 1'b0, 8'hFF, 9, 1'b0);
        apply_stimulus(1'b1, 8'h00);
        tick();
        check_word("b2b 00", 1'b0, 8'h00, 9, 1'b0);
        load_valid = 1'b0;
        tick();
        check_idle("b2b idle", 1'b0);

        // load_valid/din wiggling during a word must not disturb it
        apply_stimulus(1'b1, 8'hA5);
        tick();
        check_word("toggle", 1'b0, 8'hA5, 9, 1'b1);
        load_valid = 1'b0;
        tick();
        check_idle("toggle idle", 1'b0);

        // Reset on the 4th bit aborts the word
        apply_stimulus(1'b1, 8'hA5);
        tick();
        check_word("abort", 1'b0, 8'hA5, 4, 1'b0);
        reset = 1'b1;
        #2;
        check_cycle("abort async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_cycle("abort next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        check_idle("abort idle", 1'b0);
        apply_stimulus(1'b1, 8'h5A);
        tick();
        check_word("5a", 1'b0, 8'h5A, 9, 1'b0);
        load_valid = 1'b0;
        tick();
        check_idle("5a idle", 1'b0);

`ifdef PISO_PARITY_EN
        // Parity bit values for odd and even population counts
        apply_stimulus(1'b1, 8'h07);
        tick();
        check_word("p07", 1'b0, 8'h07, 9, 1'b0);
        check_output("p07 parity value", m_sout, 1'b1);
        tick();
        check_idle("p07 idle", 1'b0);
        apply_stimulus(1'b1, 8'h03);
        tick();
        check_word("p03", 1'b0, 8'h03, 9, 1'b0);
        check_output("p03 parity value", m_sout, 1'b0);
        tick();
        check_idle("p03 idle", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
